bsg_wormhole_test_node_client_multiflit: RTL and testbench
==========================================================

// Module: bsg_wormhole_test_node_client_multiflit
// PURPOSE
//  Parametrised wormhole test-network client node: per network, accepts whole multi-flit
//  packets and either loops each one back with its header cord rewritten to dest_cord_i,
//  or sinks (drops) it. Buffered in/out FIFOs of configurable depth; per-net packet counters.
//  Sits at a router P-port in wormhole network testbenches, opposite the test master node.
// PARAMETERS
//  flit_width_p   "inv"  flit width in bits; must be >= cord_width_p+len_width_p
//  cord_width_p   "inv"  width of header cord field (flit bits [cord_width_p-1:0])
//  len_width_p    "inv"  width of header len field (bits [cord_width_p+len_width_p-1:cord_width_p])
//  num_nets_p     2      number of independent networks/links served
//  fifo_els_p     2      depth of each in and out FIFO; >=2 required for 1 flit/cycle
//  count_width_p  16     width of each per-net packet counter
//  link_width_lp  derived `bsg_ready_and_link_sif_width(flit_width_p) = flit_width_p+2
// PORTS
//  clk_i           in   1                          clock
//  reset_i         in   1                          asynchronous, active-high reset
//  dest_cord_i     in   cord_width_p               cord written into every looped-back header
//  sink_mode_i     in   num_nets_p                 per net: 1 = drop packets, 0 = loop back
//  link_i          in   num_nets_p*link_width_lp   bsg_ready_and_link_sif {v,data,ready_and_rev}
//  link_o          out  num_nets_p*link_width_lp   bsg_ready_and_link_sif {v,data,ready_and_rev}
//  packet_count_o  out  num_nets_p*count_width_p   packets fully consumed (looped or sunk) per net
// BEHAVIOUR
//  Reset (async assert, sync-released): FIFOs emptied, FSMs -> HDR, counters 0;
//   link_o.v=0, link_o.ready_and_rev=0 while reset_i=1, =1 first cycle after (FIFO empty).
//  Nets fully independent; identical logic per net. No combinational path link_i -> link_o.
//  Input FIFO: enq on link_i.v & link_o.ready_and_rev (ready = FIFO not full).
//  Output FIFO: deq on link_o.v & link_i.ready_and_rev. Data held stable while v & ~ready.
//  Packet = header flit + len body flits (len=0 -> single-flit packet).
//  FSM per net:
//   HDR : on in-FIFO valid: latch len into body counter, latch sink_mode_i[n] into sink_r.
//         loop (sink_mode=0): header passes to out FIFO with cord field := dest_cord_i,
//         len and data fields unchanged; consumed only when out FIFO ready.
//         sink: header dequeued unconditionally. len==0 -> stay HDR, count++; else -> BODY.
//   BODY: each body flit passed unmodified (loop) or dropped (sink); counter decrements per
//         consumed flit; last flit (counter==1) -> HDR, count++.
//  sink_mode_i sampled only at header consumption; changes mid-packet ignored until next header.
//  dest_cord_i sampled when header is enqueued to out FIFO.
//  Latency (loop, empty FIFOs, ready downstream): flit on link_i at cycle t -> link_o.v at t+2.
//  Throughput: 1 flit/cycle/net sustained for fifo_els_p>=2; back-pressure propagates
//   upstream only via full FIFOs, never drops a flit in loop mode.
//  Counter wraps 2^count_width_p-1 -> 0 silently. Max len (2^len_width_p-1) fully supported.
//  Simultaneous enq/deq on full FIFO: deq takes effect, enq refused (ready low) that cycle.
//  Reset mid-packet: partial packet discarded, FSM -> HDR; next flit seen is treated as header.
// TESTING
//  1 net0 loop, cord_i=3: send hdr{cord=5,len=0,data=0xA} -> link_o hdr{cord=3,len=0,data=0xA} at t+2, count0=1.
//  2 net1 loop, len=3 packet, downstream ready every cycle -> 4 flits out back-to-back, body bits identical, count1=1.
//  3 loop, downstream ready held 0 for 20 cycles -> link_o.ready_and_rev falls after 2*fifo_els_p flits, no loss/reorder on release.
//  4 sink_mode=1, three packets len 0/2/5 -> link_o.v never 1, in-ready stays 1, count=3; toggle sink mid-packet -> packet still sunk.
//  5 count_width_p=4: 17 single-flit packets -> count reads 1 (wrap).
//  6 assert reset_i mid-body of len=4 packet -> outputs 0 immediately, count 0; new len=0 packet afterwards loops correctly.

Source files
------------

// File: rtl/bsg_wormhole_test_node_client_multiflit_if.sv
// Link bundle between a wormhole router P-port and the test client node.
// Each net occupies one bsg_ready_and_link_sif slice {v, data, ready_and_rev}
// of width flit_width_p+2, net 0 in the least significant slice.
//   link_i : router -> client  (incoming flit + downstream ready for our output)
//   link_o : client -> router  (outgoing flit + our ready for incoming flits)
// The client connects through the slave modport; the router side or a bench
// connects through master.
interface bsg_wormhole_test_node_client_multiflit_if #(
  parameter int flit_width_p = 16,
  parameter int num_nets_p   = 2
);
  localparam int link_width_lp = flit_width_p + 2;

  logic [num_nets_p*link_width_lp-1:0] link_i;
  logic [num_nets_p*link_width_lp-1:0] link_o;

  modport master (output link_i, input link_o);
  modport slave  (input link_i, output link_o);
endinterface

// File: rtl/bsg_wormhole_test_node_client_multiflit.sv
// Wormhole test-network client node. Per net it accepts whole multi-flit
// packets and either loops each one back with the header cord rewritten to
// dest_cord_i, or sinks it. Each net has an input and an output FIFO and a
// packet counter; nets are fully independent.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   dest_cord_i     cord written into every looped-back header
//   sink_mode_i     per net: 1 = drop packets, 0 = loop back
//   link            per-net ready/valid links (slave modport)
//   packet_count_o  per-net count of fully consumed packets (wraps)

// Small first-word-fall-through FIFO: data_o is the head entry whenever v_o.
module bsg_wormhole_test_node_client_multiflit_fifo #(
  parameter int width_p = 16,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [cnt_w_lp-1:0] count_reg;
  logic                enq, deq;

  // Full is judged on the registered count only, so a deq on a full FIFO
  // frees the slot for the next cycle but the same-cycle enq is refused.
  assign ready_o = (count_reg != cnt_w_lp'(els_p));
  assign v_o     = (count_reg != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq)
        wr_ptr_reg <= (wr_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_reg + ptr_w_lp'(1);
      if (deq)
        rd_ptr_reg <= (rd_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_reg + ptr_w_lp'(1);
      if (enq & ~deq)
        count_reg <= count_reg + cnt_w_lp'(1);
      else if (deq & ~enq)
        count_reg <= count_reg - cnt_w_lp'(1);
    end
  end
endmodule

module bsg_wormhole_test_node_client_multiflit #(
  parameter int flit_width_p  = 16,
  parameter int cord_width_p  = 4,
  parameter int len_width_p   = 4,
  parameter int num_nets_p    = 2,
  parameter int fifo_els_p    = 2,
  parameter int count_width_p = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [cord_width_p-1:0]             dest_cord_i,
  input  logic [num_nets_p-1:0]               sink_mode_i,
  bsg_wormhole_test_node_client_multiflit_if.slave link,
  output logic [num_nets_p*count_width_p-1:0] packet_count_o
);
  localparam int link_width_lp = flit_width_p + 2;

  typedef enum logic {HDR, BODY} state_e;

  // Holds input ready low while reset is asserted; rises on the first edge
  // after release.
  logic alive_reg;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) alive_reg <= 1'b0;
    else         alive_reg <= 1'b1;
  end

  logic [num_nets_p*link_width_lp-1:0] link_o_flat;
  assign link.link_o = link_o_flat;

  for (genvar gi = 0; gi < num_nets_p; gi++) begin : g_net
    logic                    in_link_v, down_ready;
    logic [flit_width_p-1:0] in_link_data;
    logic                    in_fifo_ready, in_fifo_v, in_yumi;
    logic [flit_width_p-1:0] in_fifo_data;
    logic                    out_fifo_ready, out_fifo_v, out_enq;
    logic [flit_width_p-1:0] out_fifo_data, out_flit;
    logic [len_width_p-1:0]  hdr_len;
    state_e                  state_reg, state_next;
    logic [len_width_p-1:0]  len_reg, len_next;
    logic                    sink_reg, sink_next;
    logic                    pkt_done;
    logic [count_width_p-1:0] count_reg;

    assign in_link_v    = link.link_i[gi*link_width_lp + flit_width_p + 1];
    assign in_link_data = link.link_i[gi*link_width_lp + 1 +: flit_width_p];
    assign down_ready   = link.link_i[gi*link_width_lp];

    bsg_wormhole_test_node_client_multiflit_fifo #(
      .width_p(flit_width_p), .els_p(fifo_els_p)
    ) in_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (in_link_data),
      .v_i     (in_link_v & alive_reg),
      .ready_o (in_fifo_ready),
      .data_o  (in_fifo_data),
      .v_o     (in_fifo_v),
      .yumi_i  (in_yumi)
    );

    bsg_wormhole_test_node_client_multiflit_fifo #(
      .width_p(flit_width_p), .els_p(fifo_els_p)
    ) out_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (out_flit),
      .v_i     (out_enq),
      .ready_o (out_fifo_ready),
      .data_o  (out_fifo_data),
      .v_o     (out_fifo_v),
      .yumi_i  (out_fifo_v & down_ready)
    );

    assign hdr_len = in_fifo_data[cord_width_p +: len_width_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        state_reg <= HDR;
        len_reg   <= '0;
        sink_reg  <= 1'b0;
        count_reg <= '0;
      end else begin
        state_reg <= state_next;
        len_reg   <= len_next;
        sink_reg  <= sink_next;
        if (pkt_done) count_reg <= count_reg + count_width_p'(1);
      end
    end

    // A flit leaves the input FIFO only when it can be fully handled this
    // cycle: always in sink mode, or when the output FIFO has room in loop mode.
    always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      sink_next  = sink_reg;
      in_yumi    = 1'b0;
      out_enq    = 1'b0;
      out_flit   = in_fifo_data;
      pkt_done   = 1'b0;
      case (state_reg)
        HDR: begin
          if (in_fifo_v) begin
            out_flit = {in_fifo_data[flit_width_p-1:cord_width_p], dest_cord_i};
            if (sink_mode_i[gi]) begin
              in_yumi = 1'b1;
            end else begin
              out_enq = out_fifo_ready;
              in_yumi = out_fifo_ready;
            end
            if (in_yumi) begin
              sink_next = sink_mode_i[gi];
              if (hdr_len == '0) begin
                pkt_done = 1'b1;
              end else begin
                len_next   = hdr_len;
                state_next = BODY;
              end
            end
          end
        end
        BODY: begin
          if (in_fifo_v) begin
            if (sink_reg) begin
              in_yumi = 1'b1;
            end else begin
              out_enq = out_fifo_ready;
              in_yumi = out_fifo_ready;
            end
            if (in_yumi) begin
              len_next = len_reg - len_width_p'(1);
              if (len_reg == len_width_p'(1)) begin
                state_next = HDR;
                pkt_done   = 1'b1;
              end
            end
          end
        end
        default: state_next = HDR;
      endcase
    end

    assign link_o_flat[gi*link_width_lp +: link_width_lp] =
      {out_fifo_v, out_fifo_data, in_fifo_ready & alive_reg};
    assign packet_count_o[gi*count_width_p +: count_width_p] = count_reg;
  end
endmodule

// File: tb/tb_bsg_wormhole_test_node_client_multiflit.sv
// Directed bench for the wormhole test client node. Inputs are driven and
// outputs sampled on the falling clock edge; a handshake seen there completes
// on the following rising edge.
module tb_bsg_wormhole_test_node_client_multiflit;
  localparam int FW   = 16;
  localparam int CW   = 4;
  localparam int LW   = 4;
  localparam int NN   = 2;
  localparam int FE   = 2;
  localparam int CNTW = 4;
  localparam int LKW  = FW + 2;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic [CW-1:0]      dest_cord_i;
  logic [NN-1:0]      sink_mode_i;
  logic [NN*CNTW-1:0] packet_count_o;

  logic [NN-1:0] tx_v, ds_ready, out_v, in_ready;
  logic [FW-1:0] tx_data [NN];
  logic [FW-1:0] out_data [NN];

  bsg_wormhole_test_node_client_multiflit_if #(.flit_width_p(FW), .num_nets_p(NN)) link_if ();

  bsg_wormhole_test_node_client_multiflit #(
    .flit_width_p(FW), .cord_width_p(CW), .len_width_p(LW),
    .num_nets_p(NN), .fifo_els_p(FE), .count_width_p(CNTW)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .dest_cord_i    (dest_cord_i),
    .sink_mode_i    (sink_mode_i),
    .link           (link_if),
    .packet_count_o (packet_count_o)
  );

  always #5 clk_i = ~clk_i;

  for (genvar gi = 0; gi < NN; gi++) begin : g_link
    assign link_if.link_i[gi*LKW +: LKW] = {tx_v[gi], tx_data[gi], ds_ready[gi]};
    assign out_v[gi]    = link_if.link_o[gi*LKW + LKW - 1];
    assign out_data[gi] = link_if.link_o[gi*LKW + 1 +: FW];
    assign in_ready[gi] = link_if.link_o[gi*LKW];
  end

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [FW-1:0]   tx_q  [NN][$];
  logic [FW-1:0]   exp_q [NN][$];
  logic [NN-1:0]   ds_en, saw_v, saw_busy;
  int              acc_cnt [NN];
  int              first_out [NN];
  int              last_out [NN];
  logic [CNTW-1:0] exp_cnt [NN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNTW-1:0] count_of(input int n);
    return packet_count_o[n*CNTW +: CNTW];
  endfunction

  // One clock cycle of the source and sink models on every net.
  task automatic cycle();
    for (int n = 0; n < NN; n++) begin
      if (tx_q[n].size() > 0) begin
        tx_v[n]    = 1'b1;
        tx_data[n] = tx_q[n][0];
        if (in_ready[n]) begin
          void'(tx_q[n].pop_front());
          acc_cnt[n]++;
        end
      end else begin
        tx_v[n] = 1'b0;
      end
      ds_ready[n] = ds_en[n];
      if (!in_ready[n]) saw_busy[n] = 1'b1;
      if (out_v[n]) begin
        saw_v[n] = 1'b1;
        if (ds_ready[n]) begin
          if (first_out[n] < 0) first_out[n] = cyc;
          last_out[n] = cyc;
          if (exp_q[n].size() == 0)
            check($sformatf("extra_flit_net%0d", n), exp_q[n].size(), 1);
          else
            check($sformatf("flit_net%0d", n), out_data[n], exp_q[n].pop_front());
        end
      end
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic run_idle(input int budget);
    int k;
    k = 0;
    while ((tx_q[0].size() + tx_q[1].size() + exp_q[0].size() + exp_q[1].size()) > 0
           && k < budget) begin
      cycle();
      k++;
    end
    check("drain_net0", tx_q[0].size() + exp_q[0].size(), 0);
    check("drain_net1", tx_q[1].size() + exp_q[1].size(), 0);
    repeat (4) cycle();
  endtask

  // Queue a packet; when looped, the expected header carries dest_cord_i.
  task automatic send_pkt(input int n, input logic [CW-1:0] cord, input int len,
                          input logic [7:0] data, input bit loop);
    logic [FW-1:0] flit;
    flit = {data, LW'(len), cord};
    tx_q[n].push_back(flit);
    if (loop) exp_q[n].push_back({data, LW'(len), dest_cord_i});
    for (int i = 1; i <= len; i++) begin
      flit = FW'(16'h5A00 + i * 16'h0111) ^ {8'h00, data};
      tx_q[n].push_back(flit);
      if (loop) exp_q[n].push_back(flit);
    end
    exp_cnt[n] = exp_cnt[n] + CNTW'(1);
    $display("[TB] net %0d packet cord=%0d len=%0d data=0x%0h %s",
             n, cord, len, data, loop ? "loop" : "sink");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i     = 1'b1;
    dest_cord_i = 4'd3;
    sink_mode_i = '0;
    tx_v        = '0;
    ds_ready    = '0;
    ds_en       = '1;
    saw_v       = '0;
    saw_busy    = '0;
    for (int n = 0; n < NN; n++) begin
      tx_data[n]   = '0;
      acc_cnt[n]   = 0;
      first_out[n] = -1;
      last_out[n]  = -1;
      exp_cnt[n]   = '0;
    end

    // Reset state
    #1;
    check("rst_out_v", out_v, 2'b00);
    check("rst_in_ready", in_ready, 2'b00);
    check("rst_count", packet_count_o, 8'h00);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("in_ready_after_rst", in_ready, 2'b11);

    // Test 1: single-flit loop on net 0, latency two cycles
    ds_ready   = 2'b11;
    tx_v[0]    = 1'b1;
    tx_data[0] = 16'h0A05;
    @(negedge clk_i);
    tx_v[0] = 1'b0;
    check("t1_v_at_t1", out_v[0], 1'b0);
    @(negedge clk_i);
    check("t1_v_at_t2", out_v[0], 1'b1);
    check("t1_hdr", out_data[0], 16'h0A03);
    check("t1_count0", count_of(0), 4'd1);
    @(negedge clk_i);
    check("t1_v_drained", out_v[0], 1'b0);
    exp_cnt[0] = 4'd1;

    // Test 2: len=3 loop on net 1, four flits back to back
    dest_cord_i = 4'd9;
    first_out[1] = -1;
    send_pkt(1, 4'd7, 3, 8'h3C, 1'b1);
    run_idle(50);
    check("t2_span", last_out[1] - first_out[1], 3);
    check("t2_count1", count_of(1), 4'd1);

    // Test 3: downstream stalled on net 0, back-pressure after 2*FE flits
    acc_cnt[0]  = 0;
    saw_busy[0] = 1'b0;
    ds_en[0]    = 1'b0;
    send_pkt(0, 4'd2, 7, 8'h77, 1'b1);
    repeat (20) cycle();
    check("t3_accepted", acc_cnt[0], 2 * FE);
    check("t3_ready_fell", saw_busy[0], 1'b1);
    ds_en[0] = 1'b1;
    run_idle(100);
    check("t3_count0", count_of(0), 4'd2);

    // Test 4: sink mode on net 1
    sink_mode_i[1] = 1'b1;
    saw_v[1]       = 1'b0;
    saw_busy[1]    = 1'b0;
    send_pkt(1, 4'd1, 0, 8'h11, 1'b0);
    send_pkt(1, 4'd2, 2, 8'h22, 1'b0);
    send_pkt(1, 4'd3, 5, 8'h33, 1'b0);
    run_idle(100);
    check("t4_no_out_v", saw_v[1], 1'b0);
    check("t4_in_ready_held", saw_busy[1], 1'b0);
    check("t4_count1", count_of(1), 4'd4);
    send_pkt(1, 4'd4, 5, 8'h44, 1'b0);
    repeat (3) cycle();
    sink_mode_i[1] = 1'b0;
    run_idle(50);
    check("t4_toggle_no_out_v", saw_v[1], 1'b0);
    check("t4_toggle_count1", count_of(1), 4'd5);
    check("t4_model_count1", count_of(1), exp_cnt[1]);

    // Test 6: reset mid-body of a len=4 packet
    send_pkt(0, 4'd1, 4, 8'hE6, 1'b1);
    repeat (3) cycle();
    reset_i = 1'b1;
    #1;
    check("t6_rst_out_v", out_v, 2'b00);
    check("t6_rst_in_ready", in_ready, 2'b00);
    check("t6_rst_count", packet_count_o, 8'h00);
    tx_v = '0;
    for (int n = 0; n < NN; n++) begin
      tx_q[n].delete();
      exp_q[n].delete();
      exp_cnt[n] = '0;
    end
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("t6_in_ready_after", in_ready, 2'b11);
    send_pkt(0, 4'd4, 0, 8'h42, 1'b1);
    run_idle(20);
    check("t6_count0", count_of(0), 4'd1);
    check("t6_count1", count_of(1), 4'd0);

    // Test 5: 17 single-flit packets on net 1 wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++)
      send_pkt(1, CW'(i), 0, 8'(i + 8'h80), 1'b1);
    run_idle(100);
    check("t5_wrap_count1", count_of(1), 4'd1);
    check("t5_model_count1", count_of(1), exp_cnt[1]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
